// File: rtl/palette_pkg.sv
// Shared palette types and fixed 32-entry RGB colour table.
// Used by palette_lookup_arbiter (colour key via PALETTE_ARB_COLORKEY_EN).
package palette_pkg;

    typedef logic [23:0] rgb_t;
    typedef logic [4:0]  pal_idx_t;

    localparam pal_idx_t PAL_KEY_IDX  = 5'h00;
    localparam pal_idx_t PAL_LAST_IDX = 5'h11;

    // Entries past PAL_LAST_IDX are black.
    localparam rgb_t PAL_COLORS [32] = '{
        24'h800080, 24'hfccfcc, 24'hcfebfe, 24'hd7ecfe,
        24'he0f1ff, 24'hfff3ec, 24'hfdfdfd, 24'h1b1b1b,
        24'hf81d12, 24'hebd1c4, 24'heed4c7, 24'h2b1b09,
        24'hffbf80, 24'hffe78d, 24'hfafecb, 24'hc0e1fc,
        24'h996633, 24'hffcc66, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

endpackage

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from r_ptr,
// pointer moves past the winner when advance is high.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;
    logic          w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_next  = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[PW'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_found = 1'b1;
                grant[PW'((int'(r_ptr) + k) % NUM_REQ)] = 1'b1;
                w_next = PW'((int'(r_ptr) + k + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= w_next;
        end
    end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shared sprite palette with round-robin access and 1-cycle registered reply.
// Define PALETTE_ARB_COLORKEY_EN to make index 0 a transparent colour key.
module palette_lookup_arbiter
    import palette_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 5,
    parameter int RGB_W   = 24
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [RGB_W-1:0]         rsp_rgb,
    output logic                     rsp_transparent,
    output logic                     busy
);

    logic [NUM_REQ-1:0] w_grant;
    logic               w_advance;
    logic [IDX_W-1:0]   w_idx;
    logic [RGB_W-1:0]   w_rgb;
    logic               w_key;

    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [RGB_W-1:0]   r_rsp_rgb;
    logic               r_rsp_key;

    assign w_advance = |req_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .req     (req_valid),
        .advance (w_advance),
        .grant   (w_grant)
    );

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx |= req_index[i*IDX_W +: IDX_W] & {IDX_W{w_grant[i]}};
        end
    end

    always_comb begin
        w_rgb = '0;
        case (w_idx) inside
            [IDX_W'(0):IDX_W'(PAL_LAST_IDX)]:
                w_rgb = RGB_W'(PAL_COLORS[pal_idx_t'(w_idx)]);
            default:
                w_rgb = '0;
        endcase
`ifdef PALETTE_ARB_COLORKEY_EN
        w_key = (w_idx == IDX_W'(PAL_KEY_IDX));
        if (w_key) begin
            w_rgb = '0;
        end
`else
        w_key = 1'b0;
`endif
    end

    // Colour only reloads on acceptance so it holds between pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rsp_valid <= '0;
            r_rsp_rgb   <= '0;
            r_rsp_key   <= 1'b0;
        end else begin
            r_rsp_valid <= w_grant;
            if (|w_grant) begin
                r_rsp_rgb <= w_rgb;
                r_rsp_key <= w_key;
            end
        end
    end

    assign req_ready       = w_grant;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rgb         = r_rsp_rgb;
    assign rsp_transparent = r_rsp_key;
    assign busy            = (|req_valid) | (|r_rsp_valid);

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed + random bench for palette_lookup_arbiter against a queue-free
// behavioural model (palette table, rotating priority, 1-cycle reply).
module tb_palette_lookup_arbiter;

    localparam int N = 4;
    localparam int IW = 5;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [N-1:0]  req_valid;
    logic [N*IW-1:0] req_index;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [23:0]   rsp_rgb;
    logic          rsp_transparent;
    logic          busy;

    int checks = 0;
    int failures = 0;

    // Model state
    int           m_ptr;
    logic [N-1:0] m_rsp_valid;
    logic [23:0]  m_rgb;
    logic         m_key;
    int           m_wait [N];

    palette_lookup_arbiter #(.NUM_REQ(N), .IDX_W(IW), .RGB_W(24)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .req_valid       (req_valid),
        .req_index       (req_index),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rgb         (rsp_rgb),
        .rsp_transparent (rsp_transparent),
        .busy            (busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] pal(input int idx);
        logic [23:0] t [18] = '{
            24'h800080, 24'hfccfcc, 24'hcfebfe, 24'hd7ecfe, 24'he0f1ff,
            24'hfff3ec, 24'hfdfdfd, 24'h1b1b1b, 24'hf81d12, 24'hebd1c4,
            24'heed4c7, 24'h2b1b09, 24'hffbf80, 24'hffe78d, 24'hfafecb,
            24'hc0e1fc, 24'h996633, 24'hffcc66};
        if (idx > 17) return 24'h0;
`ifdef PALETTE_ARB_COLORKEY_EN
        if (idx == 0) return 24'h0;
`endif
        return t[idx];
    endfunction

    function automatic logic is_key(input int idx);
`ifdef PALETTE_ARB_COLORKEY_EN
        return idx == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_rsp_valid = '0;
        m_rgb = '0;
        m_key = 1'b0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    // Called at negedge: drive, check comb grant, clock, check reply.
    task automatic step(input logic [N-1:0] v, input int i0, input int i1,
                        input int i2, input int i3);
        int w;
        int ix [N];
        logic [N-1:0] g;
        ix = '{i0, i1, i2, i3};
        req_valid = v;
        for (int i = 0; i < N; i++) req_index[i*IW +: IW] = IW'(ix[i]);
        #1;
        w = winner(v);
        g = (w < 0) ? '0 : N'(1 << w);
        chk("req_ready", 32'(req_ready), 32'(g));
        chk("busy", 32'(busy), 32'((|v) | (|m_rsp_valid)));
        @(posedge Clk);
        m_rsp_valid = g;
        for (int i = 0; i < N; i++) begin
            if (v[i] && i != w) m_wait[i]++;
            else m_wait[i] = 0;
            if (m_wait[i] >= N) chk("starve", 32'(m_wait[i]), 32'(0));
        end
        if (w >= 0) begin
            m_rgb = pal(ix[w]);
            m_key = is_key(ix[w]);
            m_ptr = (w + 1) % N;
        end
        @(negedge Clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        chk("rsp_rgb", 32'(rsp_rgb), 32'(m_rgb));
        chk("rsp_transparent", 32'(rsp_transparent), 32'(m_key));
    endtask

    initial begin
        Reset_n = 1'b0;
        req_valid = 4'b1111;
        req_index = '0;
        model_reset();
        // 1. reset
        repeat (2) @(negedge Clk);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rgb", 32'(rsp_rgb), 32'h0);
        chk("rst_transp", 32'(rsp_transparent), 32'h0);
        Reset_n = 1'b1;
        step(4'b0000, 0, 0, 0, 0);
        // 2. single requester
        step(4'b0100, 0, 0, 5'h01, 0);
        step(4'b0100, 0, 0, 5'h10, 0);
        step(4'b0100, 0, 0, 5'h11, 0);
        step(4'b0100, 0, 0, 5'h1f, 0);
        step(4'b0000, 0, 0, 0, 0);
        // 3. all four continuously
        for (int c = 0; c < 8; c++) step(4'b1111, 2, 3, 4, 5);
        step(4'b0000, 0, 0, 0, 0);
        // 4. fairness: put pointer at 1 then hold 0 and 3
        step(4'b0001, 6, 0, 0, 0);
        for (int c = 0; c < 6; c++) step(4'b1001, 7, 0, 0, 8);
        // 6. colour key index
        step(4'b0010, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0);
        // 5. async reset one cycle after acceptance
        req_valid = 4'b0001;
        req_index = '0;
        req_index[IW-1:0] = 5'h09;
        @(posedge Clk);
        #2;
        req_valid = 4'b0000;
        chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
        Reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 32'(rsp_valid), 32'h0);
        chk("async_rst_rgb", 32'(rsp_rgb), 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step(4'b0000, 0, 0, 0, 0);
        step(4'b1111, 3, 4, 5, 6);
        // random
        for (int c = 0; c < 300; c++) begin
            step(N'($urandom), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
